// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer (start, data LSB first, optional parity, stop).
// Define UART_TX_BACK2BACK_EN to allow a new frame to start directly from STOP.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_data_valid,
    input  logic             i_par_en,
    input  logic             i_par_typ,
    output logic             o_data_load,
    output logic             o_ser_en,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [1:0]       o_mux_sel,
    output logic             o_par_typ_q,
    output logic             o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_par_en;
    logic             r_par_typ;
    logic             w_last;
    logic             w_accept_pt;
    assign w_last = r_bit_cnt == CNT_W'(DATA_WIDTH - 1);
`ifdef UART_TX_BACK2BACK_EN
    assign w_accept_pt = r_state == S_IDLE || r_state == S_STOP;
`else
    assign w_accept_pt = r_state == S_IDLE;
`endif
    // Gated by reset so a request during reset never reaches the datapath.
    assign o_data_load = i_rst_n & i_data_valid & w_accept_pt;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = o_data_load ? S_START : S_IDLE;
            S_START:  w_next = S_DATA;
            S_DATA:   w_next = !w_last ? S_DATA : (r_par_en ? S_PARITY : S_STOP);
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = o_data_load ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else begin
            r_state <= w_next;
            if (o_data_load) begin
                r_par_en  <= i_par_en;
                r_par_typ <= i_par_typ;
            end
            if (r_state == S_START)
                r_bit_cnt <= '0;
            else if (r_state == S_DATA && !w_last)
                r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end
    assign o_mux_sel   = r_state == S_START  ? 2'b00 :
                         r_state == S_DATA   ? 2'b10 :
                         r_state == S_PARITY ? 2'b11 : 2'b01;
    assign o_busy      = r_state != S_IDLE;
    assign o_ser_en    = r_state == S_DATA;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_par_typ_q = r_par_typ;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: table-driven frame checks with a per-cycle expected-output queue.
module tb_uart_tx_ctrl;
    localparam int DW = 8;
    localparam int CW = 3;
`ifdef UART_TX_BACK2BACK_EN
    localparam int LOAD2 = 11;
`else
    localparam int LOAD2 = 12;
`endif
    logic          clk = 1'b0;
    logic          rst_n, dv, pe, pt;
    logic          o_data_load, o_ser_en, o_par_typ_q, o_busy;
    logic [CW-1:0] o_bit_cnt;
    logic [1:0]    o_mux_sel;
    typedef struct packed {
        logic          dl;
        logic [1:0]    mux;
        logic          busy;
        logic          ser;
        logic [CW-1:0] cnt;
        logic          ptq;
    } obs_t;
    typedef struct {
        logic pe;
        logic pt;
        logic tog;
        logic noise;
        int   len;
        logic ptq;
    } vec_t;
    obs_t       q[$];
    obs_t       obs;
    vec_t       vecs[6];
    int         total = 0;
    int         bad = 0;
    logic [CW-1:0] m_cnt;
    logic       dl_log[14];
    logic [1:0] mx_log[14];
    logic       bz_log[14];

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(dv), .i_par_en(pe), .i_par_typ(pt),
        .o_data_load(o_data_load), .o_ser_en(o_ser_en), .o_bit_cnt(o_bit_cnt),
        .o_mux_sel(o_mux_sel), .o_par_typ_q(o_par_typ_q), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    assign obs = '{o_data_load, o_mux_sel, o_busy, o_ser_en, o_bit_cnt, o_par_typ_q};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input int id, input vec_t v);
        obs_t e;
        int   k;
        @(negedge clk);
        dv = 1'b1; pe = v.pe; pt = v.pt;
        #1 chk($sformatf("f%0d_accept_load", id), 32'(o_data_load), 32'd1);
        q.push_back('{1'b0, 2'b00, 1'b1, 1'b0, m_cnt, v.ptq});
        for (int i = 0; i < DW; i++) q.push_back('{1'b0, 2'b10, 1'b1, 1'b1, CW'(i), v.ptq});
        if (v.len == DW + 3) q.push_back('{1'b0, 2'b11, 1'b1, 1'b0, CW'(DW - 1), v.ptq});
        q.push_back('{1'b0, 2'b01, 1'b1, 1'b0, CW'(DW - 1), v.ptq});
        q.push_back('{1'b0, 2'b01, 1'b0, 1'b0, CW'(DW - 1), v.ptq});
        m_cnt = CW'(DW - 1);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            dv = v.noise && k >= 1 && k <= DW;
            if (v.tog && k == 3) begin pe = ~pe; pt = ~pt; end
            #1 e = q.pop_front();
            chk($sformatf("f%0d_cyc%0d", id, k), 32'(obs), 32'(e));
            k++;
        end
        dv = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; dv = 1'b1; pe = 1'b1; pt = 1'b1; m_cnt = '0;
        #1;
        chk("rst_mux", 32'(o_mux_sel), 32'h1);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_ser", 32'(o_ser_en), 32'h0);
        chk("rst_cnt", 32'(o_bit_cnt), 32'h0);
        chk("rst_ptq", 32'(o_par_typ_q), 32'h0);
        chk("rst_load", 32'(o_data_load), 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", 32'(o_busy), 32'h0);
        rst_n = 1'b1; dv = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 11, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 11, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 11, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b1};
        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        @(negedge clk);
        pe = 1'b1; pt = 1'b0; dv = 1'b1;
        for (int k = 0; k < 14; k++) begin
            #1;
            dl_log[k] = o_data_load; mx_log[k] = o_mux_sel; bz_log[k] = o_busy;
            @(negedge clk);
        end
        dv = 1'b0;
        for (int k = 0; k < 14; k++)
            chk($sformatf("b2b_load%0d", k), 32'(dl_log[k]), 32'(k == 0 || k == LOAD2));
        chk("b2b_stop_mux", 32'(mx_log[11]), 32'h1);
        chk("b2b_stop_busy", 32'(bz_log[11]), 32'h1);
        chk("b2b_gap_mux", 32'(mx_log[12]), LOAD2 == 11 ? 32'h0 : 32'h1);
        chk("b2b_gap_busy", 32'(bz_log[12]), LOAD2 == 11 ? 32'h1 : 32'h0);
        chk("b2b_next_busy", 32'(bz_log[13]), 32'h1);
        n = 0;
        while (o_busy && n < 40) begin @(negedge clk); n++; end
        chk("b2b_drain", 32'(n < 40), 32'h1);

        @(negedge clk);
        dv = 1'b1; pe = 1'b1; pt = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        n = 0;
        while (!(o_ser_en && o_bit_cnt == 3) && n < 20) begin @(negedge clk); n++; end
        chk("mid_reached_cnt3", 32'(n < 20), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mux", 32'(o_mux_sel), 32'h1);
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        chk("mid_rst_ser", 32'(o_ser_en), 32'h0);
        chk("mid_rst_cnt", 32'(o_bit_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_mux", 32'(o_mux_sel), 32'h1);
        chk("post_rst_busy", 32'(o_busy), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmitter.
- Accepts a frame request, then drives the serializer enable, the parity-calculator load strobe and the output-mux select so that each frame goes out in order: start bit, data bits (LSB first), optional parity, stop bit.
- Sits between the upstream data source and the TX datapath (serializer, parity calculator, 4:1 bit mux).
- Holds no data itself. It decides which datapath element owns the TX line on every cycle.
- One TX bit per clock; any baud-rate prescaling is applied upstream as a clock enable.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (legal range 5..9).
- CNT_W, $clog2(DATA_WIDTH), width of bit_cnt.

Ports:
- CLK  input  1  TX bit clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- DATA_VALID  input  1  frame request. Sampled only when the controller can accept (see Operation).
- PAR_EN  input  1  frame carries a parity bit. Sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd. Sampled on acceptance.
- data_load  output  1  combinational acceptance strobe. Serializer and parity calculator capture P_DATA on the same rising edge.
- ser_en  output  1  serializer shift enable. High for every DATA-state cycle.
- bit_cnt  output  CNT_W  index of the data bit currently on the line.
- mux_sel  output  2  TX mux select: 00 start (0), 01 stop/idle (1), 10 serial data, 11 parity bit.
- par_typ_q  output  1  PAR_TYP latched at acceptance, fed to the parity calculator.
- busy  output  1  high from the cycle after acceptance through the last stop cycle.

## Operation
States and what each drives:
- IDLE: mux_sel=01, busy=0, ser_en=0.
- START: mux_sel=00, busy=1.
- DATA: mux_sel=10, ser_en=1, bit_cnt counts 0..DATA_WIDTH-1.
- PARITY: mux_sel=11.
- STOP: mux_sel=01, busy=1.

Transitions:
- IDLE -> START when DATA_VALID=1. data_load = DATA_VALID & (state==IDLE). PAR_EN and PAR_TYP are latched into par_en_q and par_typ_q on that edge.
- START -> DATA after 1 cycle. bit_cnt is cleared to 0.
- DATA stays in DATA while bit_cnt < DATA_WIDTH-1, incrementing each cycle. At bit_cnt = DATA_WIDTH-1 it goes to PARITY if par_en_q, else STOP.
- PARITY -> STOP after 1 cycle.
- STOP -> IDLE after 1 cycle (see Configuration for the back-to-back case).

Boundary rules:
- Frame length from START = 2 + DATA_WIDTH + par_en_q cycles: 11 with parity, 10 without, at DATA_WIDTH=8.
- DATA_VALID while busy (outside the accept points) is ignored and not queued; data_load stays 0.
- PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
- bit_cnt holds its value outside DATA and never exceeds DATA_WIDTH-1. There is no wrap inside a frame.
- Reset mid-frame: the FSM returns to IDLE immediately and asynchronously, and the line goes high (mux_sel=01). No partial frame resumes after reset.

## Timing
- Reset values: state IDLE, mux_sel=01, busy=0, ser_en=0, data_load=0 (DATA_VALID is ignored while RST=0), bit_cnt=0, par_typ_q=0.
- All outputs except data_load are registered state decodes. data_load is combinational from DATA_VALID.
- Latency: DATA_VALID high at edge N puts the start bit on the line during cycle N+1, with busy=1 from N+1.
- First data bit: cycle N+2.
- Parity bit: cycle N+2+DATA_WIDTH.
- busy falls on the edge that ends STOP.
- Minimum gap between frames without the macro: 1 IDLE cycle, so 1 idle-high bit.

## Configuration
- UART_TX_BACK2BACK_EN defined: in STOP, DATA_VALID=1 asserts data_load, latches PAR_EN/PAR_TYP, and goes STOP -> START directly. busy stays 1 and there are zero idle bits between frames.
- Macro undefined: DATA_VALID in STOP is ignored, and STOP always returns to IDLE.

## Test plan
- Reset: hold RST=0 from time 0 -> mux_sel=01, busy=0, ser_en=0, bit_cnt=0. Assert RST=0 mid-DATA at bit_cnt=3 -> IDLE on the same clock phase, mux_sel=01.
- PAR_EN=1, PAR_TYP=0, DATA_VALID pulsed 1 cycle -> data_load high that cycle; mux_sel sequence 00, 10×8, 11, 01 over 11 cycles; bit_cnt 0..7 during DATA; par_typ_q=0; busy high for exactly 11 cycles.
- PAR_EN=0 -> mux_sel 00, 10×8, 01 over 10 cycles; the PARITY state never entered.
- PAR_TYP=1 at acceptance, toggled to 0 and PAR_EN toggled during DATA -> par_typ_q stays 1 and the parity cycle is still present.
- DATA_VALID held high for the whole frame, macro off -> second data_load exactly 1 cycle after busy falls, with one mux_sel=01 idle cycle between frames.
- Same stimulus with UART_TX_BACK2BACK_EN -> data_load fires in the STOP cycle, the next cycle has mux_sel=00, and busy never drops between frames.
